// File: rtl/mul_acc_drain.sv
// mul_acc_drain: drains products from a sequential multiplier through its
// rd_ready/rd_en handshake and sums VEC_LEN of them into one dot-product
// result. The result is presented on a valid/ready port. While a result
// waits for the consumer, the read strobe is withheld so the multiplier
// stalls.
//
// Build option: define MUL_ACC_SAT_EN to clamp the accumulator at all-ones
// on carry-out. Without it, the accumulator wraps modulo 2^ACC_WIDTH.
// In both builds, ovf reports that a carry occurred in the emitted sum.
module mul_acc_drain #(
    parameter int RES_WIDTH = 64,
    parameter int VEC_LEN   = 4,
    parameter int ACC_WIDTH = RES_WIDTH + $clog2(VEC_LEN + 1),
    parameter int CNT_WIDTH = $clog2(VEC_LEN + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 mul_rd_ready,
    input  logic [RES_WIDTH-1:0] mul_rd_data,
    output logic                 mul_rd_en,
    input  logic                 flush,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_WIDTH-1:0] out_cnt,
    output logic                 ovf
);

    // Count value at which the next handshake completes a full vector.
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(VEC_LEN - 1);

    typedef enum logic {
        ACCUM = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t                 state_reg;
    logic [ACC_WIDTH-1:0]   acc_reg;
    logic [CNT_WIDTH-1:0]   cnt_reg;
    logic                   ovf_int_reg;
    logic [ACC_WIDTH-1:0]   out_data_reg;
    logic                   out_valid_reg;
    logic [CNT_WIDTH-1:0]   out_cnt_reg;
    logic                   ovf_reg;

    logic                   hs;
    logic                   close_vec;
    logic [ACC_WIDTH:0]     prod_ext;
    logic [ACC_WIDTH:0]     sum_wide;
    logic                   carry;
    logic [ACC_WIDTH-1:0]   acc_next;
    logic [CNT_WIDTH-1:0]   cnt_next;
    logic                   ovf_next;

    // Read strobe: a product is taken only while accumulating and the
    // multiplier has one ready; stale data is never sampled.
    assign hs        = (state_reg == ACCUM) && mul_rd_ready;
    assign mul_rd_en = hs;

    // Candidate accumulator update. The product is zero-extended one bit
    // beyond the accumulator so the carry-out can be observed.
    always_comb begin
        prod_ext = {{(ACC_WIDTH + 1 - RES_WIDTH){1'b0}}, mul_rd_data};
        sum_wide = {1'b0, acc_reg} + prod_ext;
        carry    = sum_wide[ACC_WIDTH];
        acc_next = acc_reg;
        cnt_next = cnt_reg;
        ovf_next = ovf_int_reg;
        if (hs) begin
`ifdef MUL_ACC_SAT_EN
            // A saturated accumulator stays at all-ones: any further
            // non-zero addend produces a carry and clamps again.
            acc_next = carry ? {ACC_WIDTH{1'b1}} : sum_wide[ACC_WIDTH-1:0];
`else
            acc_next = sum_wide[ACC_WIDTH-1:0];
`endif
            cnt_next = cnt_reg + CNT_WIDTH'(1);
            ovf_next = ovf_int_reg | carry;
        end
    end

    // A vector closes on its last product, or on flush when there is at
    // least one product to report (already held or arriving now).
    always_comb begin
        close_vec = 1'b0;
        if (state_reg == ACCUM) begin
            if (hs && (cnt_reg == LAST_CNT)) begin
                close_vec = 1'b1;
            end
            if (flush && ((cnt_reg != '0) || hs)) begin
                close_vec = 1'b1;
            end
        end
    end

    // Control FSM with registered result outputs; reset discards any partial sum.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ACCUM;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            ovf_int_reg   <= 1'b0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_cnt_reg   <= '0;
            ovf_reg       <= 1'b0;
        end else begin
            case (state_reg)
                ACCUM: begin
                    if (close_vec) begin
                        out_data_reg  <= acc_next;
                        out_cnt_reg   <= cnt_next;
                        ovf_reg       <= ovf_next;
                        out_valid_reg <= 1'b1;
                        acc_reg       <= '0;
                        cnt_reg       <= '0;
                        ovf_int_reg   <= 1'b0;
                        state_reg     <= HOLD;
                    end else if (hs) begin
                        acc_reg       <= acc_next;
                        cnt_reg       <= cnt_next;
                        ovf_int_reg   <= ovf_next;
                    end
                end
                HOLD: begin
                    // Result registers stay frozen until the consumer takes them.
                    if (out_valid_reg && out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= ACCUM;
                    end
                end
                default: begin
                    state_reg <= ACCUM;
                end
            endcase
        end
    end

    assign out_data  = out_data_reg;
    assign out_valid = out_valid_reg;
    assign out_cnt   = out_cnt_reg;
    assign ovf       = ovf_reg;

endmodule

// File: tb/tb_mul_acc_drain.sv
// Directed testbench for mul_acc_drain. Three instances are used:
//   u_main  : default parameters (RES 64, VEC_LEN 4)
//   u_small : RES 8, ACC 8, VEC_LEN 2 for carry / saturation behaviour
//   u_one   : RES 16, VEC_LEN 1 for single-product throughput
// Inputs are driven 1ns after posedge. Outputs are sampled then, or at negedge
// for the combinational read strobe.
module tb_mul_acc_drain;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // u_main signals
    logic        m_rdy = 1'b0;
    logic [63:0] m_data = '0;
    logic        m_en;
    logic        m_flush = 1'b0;
    logic [66:0] m_odata;
    logic        m_ovalid;
    logic        m_oready = 1'b0;
    logic [2:0]  m_ocnt;
    logic        m_ovf;

    // u_small signals
    logic        s_rdy = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_en;
    logic        s_flush = 1'b0;
    logic [7:0]  s_odata;
    logic        s_ovalid;
    logic        s_oready = 1'b0;
    logic [1:0]  s_ocnt;
    logic        s_ovf;

    // u_one signals
    logic        o_rdy = 1'b0;
    logic [15:0] o_data = '0;
    logic        o_en;
    logic        o_flush = 1'b0;
    logic [16:0] o_odata;
    logic        o_ovalid;
    logic        o_oready = 1'b0;
    logic [0:0]  o_ocnt;
    logic        o_ovf;

    mul_acc_drain u_main (
        .clk(clk), .reset(reset),
        .mul_rd_ready(m_rdy), .mul_rd_data(m_data), .mul_rd_en(m_en),
        .flush(m_flush),
        .out_data(m_odata), .out_valid(m_ovalid), .out_ready(m_oready),
        .out_cnt(m_ocnt), .ovf(m_ovf)
    );

    mul_acc_drain #(.RES_WIDTH(8), .VEC_LEN(2), .ACC_WIDTH(8)) u_small (
        .clk(clk), .reset(reset),
        .mul_rd_ready(s_rdy), .mul_rd_data(s_data), .mul_rd_en(s_en),
        .flush(s_flush),
        .out_data(s_odata), .out_valid(s_ovalid), .out_ready(s_oready),
        .out_cnt(s_ocnt), .ovf(s_ovf)
    );

    mul_acc_drain #(.RES_WIDTH(16), .VEC_LEN(1)) u_one (
        .clk(clk), .reset(reset),
        .mul_rd_ready(o_rdy), .mul_rd_data(o_data), .mul_rd_en(o_en),
        .flush(o_flush),
        .out_data(o_odata), .out_valid(o_ovalid), .out_ready(o_oready),
        .out_cnt(o_ocnt), .ovf(o_ovf)
    );

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        n_checks++;
        if (m_ovalid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: actual=%0b required=0", m_ovalid); end
        n_checks++;
        if (m_odata !== 67'd0) begin n_fail++; $display("FAIL reset_data: actual=%0d required=0", m_odata); end
        n_checks++;
        if (m_ocnt !== 3'd0) begin n_fail++; $display("FAIL reset_cnt: actual=%0d required=0", m_ocnt); end
        n_checks++;
        if (m_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: actual=%0b required=0", m_ovf); end
        n_checks++;
        if (m_en !== 1'b0) begin n_fail++; $display("FAIL reset_en_idle: actual=%0b required=0", m_en); end
        step();
        // Strobe follows rd_ready in ACCUM; drop rd_ready before the edge so no product is taken.
        m_rdy = 1'b1;
        @(negedge clk);
        n_checks++;
        if (m_en !== 1'b1) begin n_fail++; $display("FAIL reset_en_accum: actual=%0b required=1", m_en); end
        m_rdy = 1'b0;
        step();
        $display("txn reset: outputs idle");
    endtask

    task automatic test_accumulate();
        logic [63:0] vals [4];
        vals = '{64'd3, 64'd5, 64'd7, 64'd11};
        for (int i = 0; i < 4; i++) begin
            m_rdy  = 1'b1;
            m_data = vals[i];
            @(negedge clk);
            n_checks++;
            if (m_en !== 1'b1) begin n_fail++; $display("FAIL acc_en_%0d: actual=%0b required=1", i, m_en); end
            step();
            m_rdy  = 1'b0;
            m_data = 64'hDEAD_BEEF;   // stale data must be ignored
            if (i < 3) begin
                n_checks++;
                if (m_ovalid !== 1'b0) begin n_fail++; $display("FAIL acc_early_valid_%0d: actual=%0b required=0", i, m_ovalid); end
                @(negedge clk);
                n_checks++;
                if (m_en !== 1'b0) begin n_fail++; $display("FAIL acc_en_idle_%0d: actual=%0b required=0", i, m_en); end
                step();
            end
        end
        n_checks++;
        if (m_ovalid !== 1'b1) begin n_fail++; $display("FAIL acc_valid: actual=%0b required=1", m_ovalid); end
        n_checks++;
        if (m_odata !== 67'd26) begin n_fail++; $display("FAIL acc_data: actual=%0d required=26", m_odata); end
        n_checks++;
        if (m_ocnt !== 3'd4) begin n_fail++; $display("FAIL acc_cnt: actual=%0d required=4", m_ocnt); end
        n_checks++;
        if (m_ovf !== 1'b0) begin n_fail++; $display("FAIL acc_ovf: actual=%0b required=0", m_ovf); end
        $display("txn accumulate: out_data=%0d out_cnt=%0d ovf=%0b", m_odata, m_ocnt, m_ovf);
    endtask

    task automatic test_backpressure();
        m_oready = 1'b0;
        m_rdy    = 1'b1;
        m_data   = 64'd77;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (m_en !== 1'b0) begin n_fail++; $display("FAIL hold_en_%0d: actual=%0b required=0", c, m_en); end
            n_checks++;
            if (m_ovalid !== 1'b1) begin n_fail++; $display("FAIL hold_valid_%0d: actual=%0b required=1", c, m_ovalid); end
            n_checks++;
            if (m_odata !== 67'd26) begin n_fail++; $display("FAIL hold_data_%0d: actual=%0d required=26", c, m_odata); end
        end
        step();
        m_oready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (m_en !== 1'b0) begin n_fail++; $display("FAIL hold_en_accept: actual=%0b required=0", m_en); end
        step();
        m_oready = 1'b0;
        n_checks++;
        if (m_ovalid !== 1'b0) begin n_fail++; $display("FAIL hold_valid_drop: actual=%0b required=0", m_ovalid); end
        n_checks++;
        if (m_odata !== 67'd26) begin n_fail++; $display("FAIL hold_data_kept: actual=%0d required=26", m_odata); end
        @(negedge clk);
        n_checks++;
        if (m_en !== 1'b1) begin n_fail++; $display("FAIL hold_en_resume: actual=%0b required=1", m_en); end
        m_rdy = 1'b0;
        step();
        $display("txn backpressure: consumed out_data=%0d", m_odata);
    endtask

    task automatic test_flush();
        m_rdy  = 1'b1;
        m_data = 64'd100;
        step();
        m_data = 64'd200;
        step();
        m_data  = 64'd50;
        m_flush = 1'b1;
        step();
        m_flush = 1'b0;
        m_rdy   = 1'b0;
        n_checks++;
        if (m_ovalid !== 1'b1) begin n_fail++; $display("FAIL flush_valid: actual=%0b required=1", m_ovalid); end
        n_checks++;
        if (m_odata !== 67'd350) begin n_fail++; $display("FAIL flush_data: actual=%0d required=350", m_odata); end
        n_checks++;
        if (m_ocnt !== 3'd3) begin n_fail++; $display("FAIL flush_cnt: actual=%0d required=3", m_ocnt); end
        $display("txn flush: out_data=%0d out_cnt=%0d", m_odata, m_ocnt);
        // Flush while holding is ignored.
        m_flush = 1'b1;
        step();
        m_flush = 1'b0;
        n_checks++;
        if (m_ovalid !== 1'b1 || m_odata !== 67'd350 || m_ocnt !== 3'd3) begin
            n_fail++; $display("FAIL flush_in_hold: actual=%0b/%0d/%0d required=1/350/3", m_ovalid, m_odata, m_ocnt);
        end
        m_oready = 1'b1;
        step();
        m_oready = 1'b0;
        // Flush with nothing accumulated emits nothing.
        m_flush = 1'b1;
        step();
        m_flush = 1'b0;
        n_checks++;
        if (m_ovalid !== 1'b0) begin n_fail++; $display("FAIL flush_empty_a: actual=%0b required=0", m_ovalid); end
        step();
        n_checks++;
        if (m_ovalid !== 1'b0) begin n_fail++; $display("FAIL flush_empty_b: actual=%0b required=0", m_ovalid); end
        // One product, then a standalone flush.
        m_rdy  = 1'b1;
        m_data = 64'd9;
        step();
        m_rdy   = 1'b0;
        m_flush = 1'b1;
        step();
        m_flush = 1'b0;
        n_checks++;
        if (m_ovalid !== 1'b1 || m_odata !== 67'd9 || m_ocnt !== 3'd1) begin
            n_fail++; $display("FAIL flush_single: actual=%0b/%0d/%0d required=1/9/1", m_ovalid, m_odata, m_ocnt);
        end
        $display("txn flush_single: out_data=%0d out_cnt=%0d", m_odata, m_ocnt);
        m_oready = 1'b1;
        step();
        m_oready = 1'b0;
    endtask

    task automatic test_overflow();
        logic [7:0] exp_sum;
`ifdef MUL_ACC_SAT_EN
        exp_sum = 8'd255;
`else
        exp_sum = 8'd44;
`endif
        s_rdy  = 1'b1;
        s_data = 8'd200;
        step();
        s_data = 8'd100;
        step();
        s_rdy = 1'b0;
        n_checks++;
        if (s_ovalid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid: actual=%0b required=1", s_ovalid); end
        n_checks++;
        if (s_odata !== exp_sum) begin n_fail++; $display("FAIL ovf_data: actual=%0d required=%0d", s_odata, exp_sum); end
        n_checks++;
        if (s_ovf !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: actual=%0b required=1", s_ovf); end
        n_checks++;
        if (s_ocnt !== 2'd2) begin n_fail++; $display("FAIL ovf_cnt: actual=%0d required=2", s_ocnt); end
        $display("txn overflow: out_data=%0d ovf=%0b", s_odata, s_ovf);
        s_oready = 1'b1;
        step();
        s_oready = 1'b0;
        s_rdy  = 1'b1;
        s_data = 8'd10;
        step();
        s_data = 8'd20;
        step();
        s_rdy = 1'b0;
        n_checks++;
        if (s_ovalid !== 1'b1 || s_odata !== 8'd30) begin n_fail++; $display("FAIL ovf_clean_data: actual=%0b/%0d required=1/30", s_ovalid, s_odata); end
        n_checks++;
        if (s_ovf !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared: actual=%0b required=0", s_ovf); end
        $display("txn no_overflow: out_data=%0d ovf=%0b", s_odata, s_ovf);
        s_oready = 1'b1;
        step();
        s_oready = 1'b0;
    endtask

    task automatic test_reset_mid();
        m_rdy  = 1'b1;
        m_data = 64'd8;
        step();
        m_data = 64'd9;
        step();
        m_rdy = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_checks++;
        if (m_ovalid !== 1'b0 || m_odata !== 67'd0) begin
            n_fail++; $display("FAIL rstmid_cleared: actual=%0b/%0d required=0/0", m_ovalid, m_odata);
        end
        m_rdy  = 1'b1;
        m_data = 64'd1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (i < 3) begin
                n_checks++;
                if (m_ovalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_early_%0d: actual=%0b required=0", i, m_ovalid); end
            end
        end
        m_rdy = 1'b0;
        n_checks++;
        if (m_ovalid !== 1'b1 || m_odata !== 67'd4 || m_ocnt !== 3'd4) begin
            n_fail++; $display("FAIL rstmid_result: actual=%0b/%0d/%0d required=1/4/4", m_ovalid, m_odata, m_ocnt);
        end
        $display("txn reset_mid: out_data=%0d out_cnt=%0d", m_odata, m_ocnt);
        m_oready = 1'b1;
        step();
        m_oready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [15:0] vals [6];
        int idx;
        logic hs_now;
        vals = '{16'h1234, 16'hFFFF, 16'd7, 16'd0, 16'd500, 16'd42};
        idx = 0;
        o_oready = 1'b1;
        o_rdy    = 1'b1;
        o_data   = vals[0];
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            hs_now = o_en;
            step();
            if (hs_now) begin
                n_checks++;
                if (o_ovalid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid_%0d: actual=%0b required=1", c, o_ovalid); end
                if (idx < 6) begin
                    n_checks++;
                    if (o_odata !== {1'b0, vals[idx]} || o_ocnt !== 1'b1) begin
                        n_fail++; $display("FAIL b2b_data_%0d: actual=%0d/%0d required=%0d/1", c, o_odata, o_ocnt, vals[idx]);
                    end
                    $display("txn back_to_back: out_data=%0d", o_odata);
                end
                idx++;
                if (idx < 6) o_data = vals[idx];
            end else begin
                n_checks++;
                if (o_ovalid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_%0d: actual=%0b required=0", c, o_ovalid); end
            end
        end
        o_rdy    = 1'b0;
        o_oready = 1'b0;
        n_checks++;
        if (idx !== 6) begin n_fail++; $display("FAIL b2b_count: actual=%0d required=6", idx); end
    endtask

    initial begin
        test_reset();
        test_accumulate();
        test_backpressure();
        test_flush();
        test_overflow();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_acc_drain.md
Name: mul_acc_drain

Overview:
- Downstream consumer of the sequential unsigned multiplier.
- Drains finished products through the multiplier's read handshake (rd_ready/rd_en) and accumulates VEC_LEN products into one dot-product sum.
- Presents the sum on a valid/ready output port.
- Throttles the multiplier by withholding the read strobe while a finished sum is waiting for the consumer.

Parameters:
- RES_WIDTH, 64: width of the multiplier product (mul_rd_data).
- VEC_LEN, 4: products per accumulated sum; legal range ≥1.
- ACC_WIDTH, RES_WIDTH + $clog2(VEC_LEN+1): accumulator and output width; must be ≥ RES_WIDTH.
- CNT_WIDTH, $clog2(VEC_LEN+1): product counter width (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  synchronous, active-high.
- mul_rd_ready  in  1  multiplier result available.
- mul_rd_data  in  RES_WIDTH  multiplier product; stable while mul_rd_ready=1.
- mul_rd_en  out  1  read strobe to multiplier; combinational.
- flush  in  1  close the current vector early and emit the partial sum.
- out_data  out  ACC_WIDTH  accumulated sum.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts out_data.
- out_cnt  out  CNT_WIDTH  number of products contained in out_data.
- ovf  out  1  overflow flag for the sum on out_data.

Behaviour:
- Reset values: state=ACCUM, acc=0, cnt=0, out_data=0, out_valid=0, out_cnt=0, ovf=0. Reset overrides every other input in the same cycle, including a reset issued mid-vector or while in HOLD; partial sums are discarded.
- FSM has two states, ACCUM and HOLD.
- mul_rd_en = (state==ACCUM) & mul_rd_ready. Never asserted in HOLD. Never asserted while mul_rd_ready=0.
- Handshake (hs): a cycle with mul_rd_en=1. On hs, mul_rd_data is sampled that cycle. Next: acc = acc + zero-extended mul_rd_data, cnt = cnt+1.
- Product addition: arithmetic is unsigned; the product is zero-extended to ACC_WIDTH+1 bits. Without SAT, the result is truncated to ACC_WIDTH (modulo 2^ACC_WIDTH). ovf_int is set sticky if the discarded carry bit is 1.
- Vector close: occurs on hs when cnt==VEC_LEN-1, or on flush=1 in ACCUM with (cnt>0 or hs). On close, at the next posedge:
  - out_data = final sum (this cycle's product included if hs);
  - out_cnt = product count;
  - ovf = ovf_int, with this cycle's carry included;
  - out_valid = 1;
  - acc, cnt and ovf_int are cleared;
  - state moves to HOLD.
- Output latency: out_valid rises exactly 1 cycle after the closing hs or flush.
- flush in ACCUM with cnt==0 and no hs is ignored; no empty sum is emitted.
- flush in HOLD is ignored.
- HOLD: out_data, out_cnt and ovf are held stable while out_valid=1 and out_ready=0. When out_valid & out_ready: next cycle out_valid=0 and state=ACCUM. mul_rd_en may assert in that next cycle at the earliest, giving 1 bubble.
- out_ready while out_valid=0 has no effect.
- out_data, out_cnt and ovf keep their last values after out_valid drops.
- VEC_LEN=1: every hs closes a vector. Maximum throughput is then one product per 2 cycles plus consumer stall.
- mul_rd_data is sampled only on hs. It is ignored whenever mul_rd_ready=0, even though the multiplier register may hold stale data.

Optional Feature:
- Macro: MUL_ACC_SAT_EN.
- Defined: an addition whose carry bit is 1 clamps acc to all-ones (2^ACC_WIDTH-1) and sets ovf_int. Further additions into a saturated acc stay all-ones until the vector closes.
- Undefined: modulo wrap as described in Behaviour. ovf still reports the carry, so the port set is identical in both builds.

Test Plan:
- VEC_LEN=4, products 3,5,7,11 presented with mul_rd_ready pulses → four hs; out_valid 1 cycle after 4th hs; out_data=26, out_cnt=4, ovf=0.
- out_ready held 0 for 10 cycles after out_valid, with mul_rd_ready=1 → mul_rd_en=0 throughout, out_data stable at 26; out_ready=1 → out_valid drops next cycle, mul_rd_en high the cycle after.
- Two products 100,200, then flush=1 concurrent with hs of 50 → out_data=350, out_cnt=3. A flush with cnt=0 and no hs → no out_valid.
- ACC_WIDTH=RES_WIDTH=8, VEC_LEN=2, products 200,100:
  - macro undefined → out_data=44, ovf=1;
  - MUL_ACC_SAT_EN defined → out_data=255, ovf=1.
- Reset asserted after 2 of 4 products, then products 1,1,1,1 → out_data=4, out_cnt=4; no output emitted for the aborted vector.
- VEC_LEN=1, back-to-back mul_rd_ready with out_ready=1 → one output per 2 cycles, each out_data equal to its product.
